// File: rtl/baccarat_deal_ctrl.sv
// Round sequencer for one baccarat hand: deal strobes, third-card rules,
// registered win/tie lights and saturating round tallies.
//
// state    | meaning
// ---------+----------------------------------------------
// S_P1     | deal player card 1
// S_D1     | deal banker card 1
// S_P2     | deal player card 2
// S_D2     | deal banker card 2
// S_CHECK  | naturals / player third-card decision
// S_P3     | deal player card 3
// S_BDEC   | banker decision against player's third card
// S_D3     | deal banker card 3
// S_RESULT | compare scores, latch lights, bump tally
// S_DONE   | hold result until new_round
module baccarat_deal_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             slow_clock,
  input  logic             reset,
  input  logic             step,
  input  logic             new_round,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             clear_hand,
  output logic             player_win_light,
  output logic             dealer_win_light,
  output logic             done,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties
);

  typedef enum logic [3:0] {
    S_P1, S_D1, S_P2, S_D2, S_CHECK, S_P3, S_BDEC, S_D3, S_RESULT, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic             w_adv;
  logic [3:0]       w_pc3_val;
  logic             w_banker_draws;
  logic             r_plight;
  logic             r_dlight;
  logic [CNT_W-1:0] r_pwins;
  logic [CNT_W-1:0] r_dwins;
  logic [CNT_W-1:0] r_ties;

  // Strobes are suppressed while reset is held so no card register loads.
  assign w_adv = step & ~reset;

  // Face cards and tens count zero toward the banker tableau.
  assign w_pc3_val = (pcard3 <= 4'd9) ? pcard3 : 4'd0;

  always_comb begin
    w_banker_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: w_banker_draws = 1'b1;
      4'd3:             w_banker_draws = (w_pc3_val != 4'd8);
      4'd4:             w_banker_draws = (w_pc3_val >= 4'd2) && (w_pc3_val <= 4'd7);
      4'd5:             w_banker_draws = (w_pc3_val >= 4'd4) && (w_pc3_val <= 4'd7);
      4'd6:             w_banker_draws = (w_pc3_val >= 4'd6) && (w_pc3_val <= 4'd7);
      default:          w_banker_draws = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_state <= S_P1;
    end else if (step) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    clear_hand  = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_P1: begin
        load_pcard1 = w_adv;
        w_next      = S_D1;
      end
      S_D1: begin
        load_dcard1 = w_adv;
        w_next      = S_P2;
      end
      S_P2: begin
        load_pcard2 = w_adv;
        w_next      = S_D2;
      end
      S_D2: begin
        load_dcard2 = w_adv;
        w_next      = S_CHECK;
      end
      S_CHECK: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
          w_next = S_RESULT;
        end else if (pscore <= 4'd5) begin
          w_next = S_P3;
        end else if (dscore <= 4'd5) begin
          w_next = S_D3;
        end else begin
          w_next = S_RESULT;
        end
      end
      S_P3: begin
        load_pcard3 = w_adv;
        w_next      = S_BDEC;
      end
      S_BDEC: begin
        w_next = w_banker_draws ? S_D3 : S_RESULT;
      end
      S_D3: begin
        load_dcard3 = w_adv;
        w_next      = S_RESULT;
      end
      S_RESULT: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        clear_hand = w_adv & new_round;
        w_next     = new_round ? S_P1 : S_DONE;
      end
      default: begin
        w_next = S_P1;
      end
    endcase
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_plight <= 1'b0;
      r_dlight <= 1'b0;
      r_pwins  <= '0;
      r_dwins  <= '0;
      r_ties   <= '0;
    end else if (step) begin
      if (r_state == S_RESULT) begin
        if (pscore > dscore) begin
          r_plight <= 1'b1;
          if (r_pwins != CNT_MAX) r_pwins <= r_pwins + CNT_ONE;
        end else if (dscore > pscore) begin
          r_dlight <= 1'b1;
          if (r_dwins != CNT_MAX) r_dwins <= r_dwins + CNT_ONE;
        end else begin
          r_plight <= 1'b1;
          r_dlight <= 1'b1;
          if (r_ties != CNT_MAX) r_ties <= r_ties + CNT_ONE;
        end
      end else if ((r_state == S_DONE) && new_round) begin
        r_plight <= 1'b0;
        r_dlight <= 1'b0;
      end
    end
  end

  assign player_win_light = r_plight;
  assign dealer_win_light = r_dlight;
  assign player_wins      = r_pwins;
  assign dealer_wins      = r_dwins;
  assign ties             = r_ties;

endmodule
